// File: rtl/ref_wb_drain_barrier_if.sv
// Handshake bundle between the PE array / ring interconnect and the
// reference-particle completion barrier.
interface ref_wb_drain_barrier_if #(
  parameter int NUM_PE        = 64,
  parameter int CNT_WIDTH     = 16,
  parameter int REF_CNT_WIDTH = 16
);
  logic [NUM_PE-1:0]        pe_mask;
  logic [NUM_PE-1:0]        ref_wb_issued;
  logic [NUM_PE-1:0]        pkt_inject;
  logic [NUM_PE-1:0]        pkt_eject;
  logic                     skip_drain;
  logic                     iter_clear;
  logic                     clear_err;
  logic [NUM_PE-1:0]        captured;
  logic                     draining;
  logic                     interconnect_empty;
  logic                     ref_done;
  logic [REF_CNT_WIDTH-1:0] ref_count;
  logic [CNT_WIDTH-1:0]     in_flight;
  logic                     timeout_err;
  logic                     count_err;

  modport master (
    output pe_mask, ref_wb_issued, pkt_inject, pkt_eject,
    output skip_drain, iter_clear, clear_err,
    input  captured, draining, interconnect_empty, ref_done,
    input  ref_count, in_flight, timeout_err, count_err
  );

  modport slave (
    input  pe_mask, ref_wb_issued, pkt_inject, pkt_eject,
    input  skip_drain, iter_clear, clear_err,
    output captured, draining, interconnect_empty, ref_done,
    output ref_count, in_flight, timeout_err, count_err
  );
endinterface

// File: rtl/ref_wb_drain_barrier.sv
// Per-reference completion barrier: gathers PE writeback pulses, then waits
// for the force interconnect to drain before pulsing ref_done.
module ref_wb_drain_barrier #(
  parameter int NUM_PE        = 64,
  parameter int DRAIN_MODE    = 0,
  parameter int DRAIN_CYCLES  = 64,
  parameter int CNT_WIDTH     = 16,
  parameter int REF_CNT_WIDTH = 16,
  parameter int TIMEOUT       = 4096
) (
  input logic clk,
  input logic rst,
  ref_wb_drain_barrier_if.slave bus
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(NUM_PE + 1);
  localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [NUM_PE-1:0]        captured;
  logic [DW-1:0]            drain_cnt;
  logic [TW-1:0]            timeout_cnt;
  logic [CNT_WIDTH-1:0]     in_flight;
  logic [CNT_WIDTH-1:0]     flight_nxt;
  logic [REF_CNT_WIDTH-1:0] ref_count;
  logic                     ref_done;
  logic                     timeout_err;
  logic                     count_err;

  logic          barrier;
  logic          drain_met;
  logic          enter;
  logic          done;
  logic          abort;
  logic          to_set;
  logic [PW-1:0] inj_n;
  logic [PW-1:0] ej_n;
  logic [SW-1:0] sum;
  logic [SW-1:0] diff;
  logic          under;
  logic          over;

  function automatic logic [PW-1:0] popcnt(input logic [NUM_PE-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PE; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  // Masked-off PEs count as already reported.
  assign barrier = &(captured | ~bus.pe_mask);

  assign drain_met = (DRAIN_MODE == 0)
                   ? (drain_cnt == DW'(DRAIN_CYCLES))
                   : (in_flight == '0);

  assign to_set = (state == DRAIN)
               && (timeout_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    unique case (state)
      COLLECT: begin
        if (barrier) begin
          state_nxt = DRAIN;
          enter     = 1'b1;
        end
      end
      DRAIN: begin
        if (bus.skip_drain) begin
          state_nxt = COLLECT;
          abort     = 1'b1;
        end else if (drain_met) begin
          state_nxt = COLLECT;
          done      = 1'b1;
        end
      end
    endcase
  end

  // Saturating in-flight update; both clamp directions flag count_err.
  always_comb begin
    inj_n      = popcnt(bus.pkt_inject);
    ej_n       = popcnt(bus.pkt_eject);
    sum        = SW'(in_flight) + SW'(inj_n);
    under      = sum < SW'(ej_n);
    diff       = sum - SW'(ej_n);
    over       = !under && (diff > SW'(CNT_MAX));
    flight_nxt = diff[CNT_WIDTH-1:0];
    if (under) flight_nxt = '0;
    else if (over) flight_nxt = CNT_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      captured    <= '0;
      drain_cnt   <= '0;
      timeout_cnt <= '0;
      in_flight   <= '0;
      ref_count   <= '0;
      ref_done    <= 1'b0;
      timeout_err <= 1'b0;
      count_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_flight <= flight_nxt;
      ref_done  <= done;

      if (done || abort)
        captured <= '0;
      else if (state == COLLECT)
        captured <= captured | (bus.ref_wb_issued & bus.pe_mask);

      if (enter)
        drain_cnt <= '0;
      else if (state == DRAIN && drain_cnt != DW'(DRAIN_CYCLES))
        drain_cnt <= drain_cnt + DW'(1);

      if (enter)
        timeout_cnt <= '0;
      else if (state == DRAIN && timeout_cnt != TW'(TIMEOUT))
        timeout_cnt <= timeout_cnt + TW'(1);

      if (bus.iter_clear)
        ref_count <= '0;
      else if (done)
        ref_count <= ref_count + REF_CNT_WIDTH'(1);

      timeout_err <= to_set | (timeout_err & ~bus.clear_err);
      count_err   <= under | over | (count_err & ~bus.clear_err);
    end
  end

  assign bus.captured           = captured;
  assign bus.draining           = (state == DRAIN);
  assign bus.interconnect_empty = drain_met
                                & ((DRAIN_MODE != 0) | (state == DRAIN));
  assign bus.ref_done           = ref_done;
  assign bus.ref_count          = ref_count;
  assign bus.in_flight          = in_flight;
  assign bus.timeout_err        = timeout_err;
  assign bus.count_err          = count_err;

endmodule

// File: tb/tb_ref_wb_drain_barrier.sv
// Bench for ref_wb_drain_barrier: a fixed-cycle instance (a) and a
// packet-counting instance (b), ref_done events scored against queues.
module tb_ref_wb_drain_barrier;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  int qa_cyc[$];
  int qa_cnt[$];
  int qb_cyc[$];
  int qb_cnt[$];

  int t0, s, r, u, v, x;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ref_wb_drain_barrier_if #(
    .NUM_PE(4), .CNT_WIDTH(8), .REF_CNT_WIDTH(8)
  ) a_if ();

  ref_wb_drain_barrier_if #(
    .NUM_PE(4), .CNT_WIDTH(4), .REF_CNT_WIDTH(8)
  ) b_if ();

  ref_wb_drain_barrier #(
    .NUM_PE(4), .DRAIN_MODE(0), .DRAIN_CYCLES(8),
    .CNT_WIDTH(8), .REF_CNT_WIDTH(8), .TIMEOUT(64)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(a_if.slave)
  );

  ref_wb_drain_barrier #(
    .NUM_PE(4), .DRAIN_MODE(1), .DRAIN_CYCLES(8),
    .CNT_WIDTH(4), .REF_CNT_WIDTH(8), .TIMEOUT(16)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(b_if.slave)
  );

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every ref_done must match the oldest expectation.
  always @(negedge clk) begin
    if (a_if.ref_done === 1'b1) begin
      chk("a_done_expected", 32'(qa_cyc.size() > 0), 1);
      if (qa_cyc.size() > 0) begin
        chk("a_done_cycle", cyc, qa_cyc.pop_front());
        chk("a_done_count", a_if.ref_count, qa_cnt.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (b_if.ref_done === 1'b1) begin
      chk("b_done_expected", 32'(qb_cyc.size() > 0), 1);
      if (qb_cyc.size() > 0) begin
        chk("b_done_cycle", cyc, qb_cyc.pop_front());
        chk("b_done_count", b_if.ref_count, qb_cnt.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.pe_mask = 4'hF;
    a_if.ref_wb_issued = '0;
    a_if.pkt_inject = '0;
    a_if.pkt_eject = '0;
    a_if.skip_drain = 1'b0;
    a_if.iter_clear = 1'b0;
    a_if.clear_err = 1'b0;
    b_if.pe_mask = 4'hF;
    b_if.ref_wb_issued = '0;
    b_if.pkt_inject = '0;
    b_if.pkt_eject = '0;
    b_if.skip_drain = 1'b0;
    b_if.iter_clear = 1'b0;
    b_if.clear_err = 1'b0;
    repeat (3) tick();
    @(negedge clk);

    chk("a_rst_captured", a_if.captured, 0);
    chk("a_rst_draining", a_if.draining, 0);
    chk("a_rst_ref_done", a_if.ref_done, 0);
    chk("a_rst_ref_count", a_if.ref_count, 0);
    chk("a_rst_in_flight", a_if.in_flight, 0);
    chk("a_rst_timeout_err", a_if.timeout_err, 0);
    chk("a_rst_count_err", a_if.count_err, 0);
    chk("a_rst_empty", a_if.interconnect_empty, 0);
    chk("b_rst_empty", b_if.interconnect_empty, 1);
    chk("b_rst_draining", b_if.draining, 0);

    // Mode 0 basic barrier: PEs 0,1 at t0, PEs 2,3 at t0+3.
    tick();
    rst_a = 1'b0;
    t0 = cyc;
    a_if.ref_wb_issued = 4'b0011;
    qa_cyc.push_back(t0 + 14);
    qa_cnt.push_back(1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      a_if.ref_wb_issued = (i == 3) ? 4'b1100 :
                           (i == 8) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      chk("a_draining", a_if.draining, 32'(i >= 5 && i <= 13));
      if (i == 1) chk("a_captured_t1", a_if.captured, 4'b0011);
      if (i == 4) chk("a_captured_full", a_if.captured, 4'hF);
      if (i == 12) chk("a_empty_early", a_if.interconnect_empty, 0);
      if (i == 13) chk("a_empty_last", a_if.interconnect_empty, 1);
      if (i == 14) chk("a_captured_clr", a_if.captured, 0);
    end

    // Masked PEs 1/3 never report.
    a_if.pe_mask = 4'b0101;
    tick();
    s = cyc;
    a_if.ref_wb_issued = 4'b0011;
    qa_cyc.push_back(s + 13);
    qa_cnt.push_back(2);
    for (int i = 1; i <= 14; i++) begin
      tick();
      a_if.ref_wb_issued = (i == 2) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (i == 1) chk("a_mask_cap1", a_if.captured, 4'b0001);
      if (i == 3) chk("a_mask_cap2", a_if.captured, 4'b0101);
      chk("a_mask_draining", a_if.draining, 32'(i >= 4 && i <= 12));
    end

    // Empty mask: back-to-back references, iter_clear on the third.
    a_if.pe_mask = 4'b0000;
    rst_a = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("a_rst2_ref_count", a_if.ref_count, 0);
    tick();
    rst_a = 1'b0;
    r = cyc;
    @(negedge clk);
    chk("a_zmask_collect", a_if.draining, 0);
    qa_cyc.push_back(r + 10); qa_cnt.push_back(1);
    qa_cyc.push_back(r + 20); qa_cnt.push_back(2);
    qa_cyc.push_back(r + 30); qa_cnt.push_back(0);
    qa_cyc.push_back(r + 40); qa_cnt.push_back(1);
    for (int i = 1; i <= 41; i++) begin
      tick();
      a_if.iter_clear = (i == 29);
      @(negedge clk);
      if (i == 1) chk("a_zmask_drain", a_if.draining, 1);
      if (i == 10) chk("a_b2b_gap", a_if.draining, 0);
      if (i == 11) chk("a_b2b_next", a_if.draining, 1);
      if (i == 29) chk("a_b2b_cnt2", a_if.ref_count, 2);
      if (i == 30) chk("a_iter_clear", a_if.ref_count, 0);
    end
    rst_a = 1'b1;

    // Mode 1 packet accounting.
    tick();
    rst_b = 1'b0;
    u = cyc;
    b_if.pkt_inject = 4'b0011;
    qb_cyc.push_back(u + 7);
    qb_cnt.push_back(1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      b_if.pkt_inject = (i == 1) ? 4'b0100 :
                        (i == 2) ? 4'b0001 : 4'b0000;
      b_if.pkt_eject  = (i == 2) ? 4'b0010 :
                        (i >= 3 && i <= 5) ? 4'b0001 :
                        (i == 8 || i == 10) ? 4'b0011 : 4'b0000;
      b_if.ref_wb_issued = (i == 1) ? 4'hF : 4'h0;
      b_if.clear_err = (i >= 9 && i <= 11);
      @(negedge clk);
      if (i == 1) chk("b_inflight_2", b_if.in_flight, 2);
      if (i == 2) chk("b_inflight_3", b_if.in_flight, 3);
      if (i == 3) chk("b_inflight_net", b_if.in_flight, 3);
      if (i == 3) chk("b_draining_on", b_if.draining, 1);
      if (i == 4) chk("b_inflight_dec", b_if.in_flight, 2);
      if (i == 4) chk("b_empty_busy", b_if.interconnect_empty, 0);
      if (i == 6) chk("b_inflight_0", b_if.in_flight, 0);
      if (i == 6) chk("b_empty_idle", b_if.interconnect_empty, 1);
      if (i == 6) chk("b_draining_last", b_if.draining, 1);
      if (i == 7) chk("b_draining_off", b_if.draining, 0);
      if (i == 9) chk("b_underflow_err", b_if.count_err, 1);
      if (i == 9) chk("b_underflow_clamp", b_if.in_flight, 0);
      if (i == 10) chk("b_clear_err", b_if.count_err, 0);
      if (i == 11) chk("b_set_wins", b_if.count_err, 1);
      if (i == 12) chk("b_clear_err2", b_if.count_err, 0);
    end

    // skip_drain: ignored in COLLECT, aborts DRAIN, beats the drain condition.
    tick();
    v = cyc;
    b_if.pe_mask = 4'b0011;
    b_if.ref_wb_issued = 4'b0011;
    b_if.pkt_inject = 4'b0001;
    for (int i = 1; i <= 12; i++) begin
      tick();
      b_if.pkt_inject = 4'b0000;
      b_if.pe_mask = (i < 3) ? 4'b0011 : 4'hF;
      b_if.ref_wb_issued = (i == 3) ? 4'b0100 :
                           (i == 6) ? 4'hF : 4'h0;
      b_if.skip_drain = (i == 1 || i == 4 || i == 10);
      b_if.pkt_eject = (i == 9) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      if (i == 1) chk("b_skip_inflight", b_if.in_flight, 1);
      if (i == 2) chk("b_skip_collect_ign", b_if.draining, 1);
      if (i == 4) chk("b_drain_no_capture", b_if.captured, 4'b0011);
      if (i == 5) chk("b_skip_draining", b_if.draining, 0);
      if (i == 5) chk("b_skip_captured", b_if.captured, 0);
      if (i == 8) chk("b_skip2_draining", b_if.draining, 1);
      if (i == 10) chk("b_skip2_empty", b_if.interconnect_empty, 1);
      if (i == 11) chk("b_skip2_collect", b_if.draining, 0);
      if (i == 12) chk("b_skip_ref_count", b_if.ref_count, 1);
    end

    // Timeout with one packet stuck, then clear_err and reset mid-DRAIN.
    tick();
    x = cyc;
    b_if.ref_wb_issued = 4'hF;
    b_if.pkt_inject = 4'b0001;
    for (int i = 1; i <= 22; i++) begin
      tick();
      b_if.ref_wb_issued = 4'h0;
      b_if.pkt_inject = 4'b0000;
      b_if.clear_err = (i == 19);
      rst_b = (i >= 21);
      @(negedge clk);
      if (i == 2) chk("b_to_drain", b_if.draining, 1);
      if (i == 17) chk("b_to_before", b_if.timeout_err, 0);
      if (i == 18) chk("b_to_set", b_if.timeout_err, 1);
      if (i == 18) chk("b_to_still_drain", b_if.draining, 1);
      if (i == 19) chk("b_to_sticky", b_if.timeout_err, 1);
      if (i == 20) chk("b_to_cleared", b_if.timeout_err, 0);
      if (i == 20) chk("b_to_drain_hold", b_if.draining, 1);
      if (i == 22) begin
        chk("b_mrst_draining", b_if.draining, 0);
        chk("b_mrst_in_flight", b_if.in_flight, 0);
        chk("b_mrst_ref_count", b_if.ref_count, 0);
        chk("b_mrst_captured", b_if.captured, 0);
        chk("b_mrst_empty", b_if.interconnect_empty, 1);
        chk("b_mrst_timeout_err", b_if.timeout_err, 0);
        chk("b_mrst_count_err", b_if.count_err, 0);
        chk("b_mrst_ref_done", b_if.ref_done, 0);
      end
    end

    repeat (3) tick();
    @(negedge clk);
    chk("a_done_missing", qa_cyc.size(), 0);
    chk("b_done_missing", qb_cyc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
